// File: rtl/vga_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_rx                                                     |
// | Description : VGA timing receiver. Recovers active-area x/y coordinates, |
// |               registers the monochrome pixel, checks every frame against |
// |               HACT x VACT and tracks timing lock (SEARCH/MEASURE/LOCKED).|
// | Ports       : clk, RSTn (async active-low)                               |
// |               hsync, vsync, hvalid, vvalid, pix   - timing/pixel inputs  |
// |               hcnt_o, vcnt_o, pix_valid, pix_o    - pixel output stage   |
// |               locked, frame_done, frame_ok        - frame check status   |
// |               ones_cnt                            - pix=1 count of frame |
// |               crc (only with VGA_RX_CRC_EN)       - CRC-16-CCITT of frame|
// | Options     : define VGA_RX_CRC_EN to add the per-frame pixel CRC.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_rx #(
  parameter int HACT  = 800,
  parameter int VACT  = 600,
  parameter int LOCKN = 2
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hvalid,
  input  logic        vvalid,
  input  logic        pix,
  output logic [10:0] hcnt_o,
  output logic [10:0] vcnt_o,
  output logic        pix_valid,
  output logic        pix_o,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [19:0] ones_cnt
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] crc
`endif
);

  localparam logic [1:0] c_SEARCH  = 2'd0;
  localparam logic [1:0] c_MEASURE = 2'd1;
  localparam logic [1:0] c_LOCKED  = 2'd2;

  localparam int          c_GW    = (LOCKN < 2) ? 1 : $clog2(LOCKN + 1);
  localparam logic [c_GW-1:0] c_LOCKN = c_GW'(LOCKN);
  localparam logic [10:0] c_HACT  = 11'(HACT);
  localparam logic [10:0] c_VACT  = 11'(VACT);
  localparam logic [10:0] c_XMAX  = 11'h7FF;
  localparam logic [19:0] c_OMAX  = 20'hFFFFF;

  logic [1:0]      r_state;
  logic [c_GW-1:0] r_good;
  logic            r_hvalid_d;
  logic            r_vsync_d;
  logic            r_hsync_d;
  logic            r_armed;    // a frame start has been seen since reset
  logic            r_hs_seen;  // hsync rose on this line, no hvalid fall yet
  logic [10:0]     r_x;
  logic [10:0]     r_y;
  logic            r_err;
  logic [19:0]     r_ones;

  logic            w_active;
  logic            w_hv_fall;
  logic            w_vs_rise;
  logic            w_hs_rise;
  logic            w_line_end;
  logic            w_line_err;
  logic            w_hs_err;
  logic            w_boundary;
  logic [10:0]     w_y_fin;
  logic            w_err_fin;
  logic [19:0]     w_ones_fin;
  logic            w_frame_good;
  logic [c_GW-1:0] w_good_inc;

  assign w_active   = hvalid & vvalid;
  assign w_hv_fall  = r_hvalid_d & ~hvalid;
  assign w_vs_rise  = vsync & ~r_vsync_d;
  assign w_hs_rise  = hsync & ~r_hsync_d;

  // A line only counts (and is only checked) while vertically active, so
  // horizontal activity during vertical blanking cannot fail the frame.
  assign w_line_end = w_hv_fall & vvalid;
  assign w_line_err = w_line_end & (r_x != c_HACT);
  assign w_hs_err   = w_hs_rise & vvalid & r_hs_seen & ~w_hv_fall;

  // The first vsync edge after reset only marks the start of a frame; the
  // partial frame before it is never reported.
  assign w_boundary = w_vs_rise & r_armed;

  // Frame totals including this cycle's line end / pixel, so a line that
  // closes on the same cycle as the vsync edge lands in the closing frame.
  assign w_y_fin      = (w_line_end && (r_y != c_XMAX)) ? r_y + 11'd1 : r_y;
  assign w_err_fin    = r_err | w_line_err | w_hs_err;
  assign w_ones_fin   = (w_active && pix && (r_ones != c_OMAX)) ? r_ones + 20'd1 : r_ones;
  assign w_frame_good = (w_y_fin == c_VACT) & ~w_err_fin;
  assign w_good_inc   = r_good + 1'b1;

  assign locked = (r_state == c_LOCKED);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= c_SEARCH;
      r_good     <= '0;
      r_hvalid_d <= 1'b0;
      // Starts high so a vsync already asserted at release is not an edge.
      r_vsync_d  <= 1'b1;
      r_hsync_d  <= 1'b0;
      r_armed    <= 1'b0;
      r_hs_seen  <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_err      <= 1'b0;
      r_ones     <= '0;
      hcnt_o     <= '0;
      vcnt_o     <= '0;
      pix_valid  <= 1'b0;
      pix_o      <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      ones_cnt   <= '0;
    end else begin
      r_hvalid_d <= hvalid;
      r_vsync_d  <= vsync;
      r_hsync_d  <= hsync;

      pix_valid  <= w_active;
      pix_o      <= w_active & pix;
      if (w_active) begin
        hcnt_o <= r_x;
        vcnt_o <= r_y;
      end

      frame_done <= w_boundary;

      if (w_vs_rise) begin
        r_armed   <= 1'b1;
        r_x       <= '0;
        r_y       <= '0;
        r_err     <= 1'b0;
        r_ones    <= '0;
        r_hs_seen <= 1'b0;
        if (r_armed) begin
          frame_ok <= w_frame_good;
          ones_cnt <= w_ones_fin;
          case (r_state)
            c_SEARCH: begin
              // Frame closed while searching is reported but not trusted.
              r_state <= c_MEASURE;
              r_good  <= '0;
            end
            c_MEASURE: begin
              if (!w_frame_good) begin
                r_good <= '0;
              end else if (w_good_inc == c_LOCKN) begin
                r_state <= c_LOCKED;
                r_good  <= '0;
              end else begin
                r_good <= w_good_inc;
              end
            end
            c_LOCKED: begin
              if (!w_frame_good) begin
                r_state <= c_SEARCH;
              end
            end
            default: begin
              r_state <= c_SEARCH;
              r_good  <= '0;
            end
          endcase
        end
      end else begin
        if (w_hv_fall) begin
          r_x <= '0;
        end else if (w_active && (r_x != c_XMAX)) begin
          r_x <= r_x + 11'd1;
        end
        r_y    <= w_y_fin;
        r_err  <= w_err_fin;
        r_ones <= w_ones_fin;
        if (!vvalid) begin
          r_hs_seen <= 1'b0;
        end else if (w_hs_rise) begin
          r_hs_seen <= 1'b1;
        end else if (w_hv_fall) begin
          r_hs_seen <= 1'b0;
        end
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc_run;
  logic [15:0] w_crc_nxt;

  // One CRC-16-CCITT step per active pixel, pixel treated as the next MSB.
  always_comb begin
    w_crc_nxt = r_crc_run;
    if (w_active) begin
      w_crc_nxt = {r_crc_run[14:0], 1'b0} ^ ((r_crc_run[15] ^ pix) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_crc_run <= 16'hFFFF;
      crc       <= '0;
    end else if (w_vs_rise) begin
      r_crc_run <= 16'hFFFF;
      if (r_armed) begin
        crc <= w_crc_nxt;
      end
    end else begin
      r_crc_run <= w_crc_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_rx                                                  |
// | Description : Self-checking bench for vga_rx with a small frame geometry.|
// |               Randomized pixel data, scoreboard of expected pixels and   |
// |               frame results produced by a behavioural model.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_rx;

  localparam int HACT  = 8;
  localparam int VACT  = 6;
  localparam int LOCKN = 2;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        hsync, vsync, hvalid, vvalid, pix;
  logic [10:0] hcnt_o, vcnt_o;
  logic        pix_valid, pix_o, locked, frame_done, frame_ok;
  logic [19:0] ones_cnt;
`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;
`endif

  always #5 clk = ~clk;

  vga_rx #(.HACT(HACT), .VACT(VACT), .LOCKN(LOCKN)) dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .hsync      (hsync),
    .vsync      (vsync),
    .hvalid     (hvalid),
    .vvalid     (vvalid),
    .pix        (pix),
    .hcnt_o     (hcnt_o),
    .vcnt_o     (vcnt_o),
    .pix_valid  (pix_valid),
    .pix_o      (pix_o),
    .locked     (locked),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .ones_cnt   (ones_cnt)
`ifdef VGA_RX_CRC_EN
    ,
    .crc        (crc)
`endif
  );

  typedef struct {
    logic        ok;
    logic [19:0] ones;
    logic        lk;
    logic [15:0] crc;
  } fres_t;

  int          n_chk = 0;
  int          n_bad = 0;
  int          exp_dones = 0;
  int          n_done = 0;
  logic [22:0] pixq[$];
  fres_t       fq[$];

  // reference model state
  bit          m_armed;
  int          m_phase;   // 0 search, 1 measure, 2 locked
  int          m_good;
  int          f_lines;
  bit          f_err;
  int          f_ones;
  logic [15:0] f_crc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_frame();
    f_lines = 0;
    f_err   = 1'b0;
    f_ones  = 0;
    f_crc   = 16'hFFFF;
  endtask

  // Frame boundary as seen by the model: report the closing frame if a frame
  // start was seen, and advance the lock tracker.
  task automatic boundary();
    fres_t r;
    bit    ok;
    if (m_armed) begin
      ok = (f_lines == VACT) && !f_err;
      if (m_phase == 0) begin
        m_phase = 1;
        m_good  = 0;
      end else if (m_phase == 1) begin
        if (ok) begin
          m_good++;
          if (m_good >= LOCKN) m_phase = 2;
        end else begin
          m_good = 0;
        end
      end else if (!ok) begin
        m_phase = 0;
      end
      r.ok   = ok;
      r.ones = 20'(f_ones);
      r.lk   = (m_phase == 2);
      r.crc  = f_crc;
      fq.push_back(r);
      exp_dones++;
    end
    m_armed = 1'b1;
    model_clear_frame();
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_locked"},     64'(locked),     64'd0);
    chk({pfx, "_frame_ok"},   64'(frame_ok),   64'd0);
    chk({pfx, "_ones_cnt"},   64'(ones_cnt),   64'd0);
    chk({pfx, "_hcnt"},       64'(hcnt_o),     64'd0);
    chk({pfx, "_vcnt"},       64'(vcnt_o),     64'd0);
    chk({pfx, "_pix_valid"},  64'(pix_valid),  64'd0);
    chk({pfx, "_pix_o"},      64'(pix_o),      64'd0);
    chk({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
`ifdef VGA_RX_CRC_EN
    chk({pfx, "_crc"},        64'(crc),        64'd0);
`endif
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    m_armed = 1'b0;
    m_phase = 0;
    m_good  = 0;
    model_clear_frame();
    pixq.delete();
    tick();
    tick();
    RSTn = 1'b1;
    tick();
  endtask

  task automatic do_vsync();
    vsync = 1'b1;
    boundary();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  // pat: 0 all-zero, 1 all-one, 2 random. odd_ln gets odd_len pixels,
  // dbl_ln gets an extra hsync pulse, rst_ln is preceded by a reset pulse,
  // coinc makes the last hvalid fall coincide with the vsync rise.
  task automatic run_frame(input int pat, input int nlines, input int odd_ln,
                           input int odd_len, input int dbl_ln, input int rst_ln,
                           input bit coinc, input bit chk_end);
    int len;
    int xe;
    vvalid = 1'b1;
    tick();
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln == rst_ln) do_reset();
      hsync = 1'b1; tick();
      hsync = 1'b0; tick();
      if (ln == dbl_ln) begin
        hsync = 1'b1; tick();
        hsync = 1'b0; tick();
        f_err = 1'b1;
      end
      tick();
      len = (ln == odd_ln) ? odd_len : HACT;
      for (int i = 0; i < len; i++) begin
        hvalid = 1'b1;
        pix = (pat == 0) ? 1'b0 : (pat == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        xe = (i > 2047) ? 2047 : i;
        pixq.push_back({11'(xe), 11'(f_lines), pix});
        if (pix) f_ones++;
        f_crc = crc_step(f_crc, pix);
        tick();
      end
      hvalid = 1'b0;
      pix    = 1'b0;
      f_lines++;
      if (len != HACT) f_err = 1'b1;
      if (coinc && (ln == nlines - 1)) begin
        vsync = 1'b1;
        boundary();
        tick();
        vsync = 1'b0;
      end
      tick();
      tick();
    end
    vvalid = 1'b0;
    tick();
    if (chk_end) begin
      chk("hcnt_last", 64'(hcnt_o), 64'(HACT - 1));
      chk("vcnt_last", 64'(vcnt_o), 64'(VACT - 1));
    end
    tick();
    if (!coinc) do_vsync();
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (RSTn) begin
      if (pix_valid) begin
        if (pixq.size() == 0) begin
          chk("pix_valid_unexpected", 64'(pix_valid), 64'd0);
        end else begin
          chk("pixel_xy_pix", 64'({hcnt_o, vcnt_o, pix_o}), 64'(pixq.pop_front()));
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) begin
          chk("frame_done_unexpected", 64'(frame_done), 64'd0);
        end else begin
          fres_t r;
          r = fq.pop_front();
          n_done++;
          chk("frame_ok", 64'(frame_ok), 64'(r.ok));
          chk("ones_cnt", 64'(ones_cnt), 64'(r.ones));
          chk("locked",   64'(locked),   64'(r.lk));
`ifdef VGA_RX_CRC_EN
          chk("crc",      64'(crc),      64'(r.crc));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn   = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    hvalid = 1'b0;
    vvalid = 1'b0;
    pix    = 1'b0;
    m_armed = 1'b0;
    m_phase = 0;
    m_good  = 0;
    model_clear_frame();
    repeat (3) tick();
    check_all_zero("rst");
    RSTn = 1'b1;
    tick();
    tick();

    do_vsync();                                          // frame start only
    repeat (3) run_frame(0, VACT, -1, 0, -1, -1, 0, 0);  // lock on 3rd done
    run_frame(1, VACT, -1, 0, -1, -1, 0, 1);             // all ones, locked
    repeat (2) run_frame(2, VACT, -1, 0, -1, -1, 0, 0);
    run_frame(2, VACT, 1, HACT - 1, -1, -1, 0, 0);       // short line
    run_frame(0, VACT, -1, 0, -1, -1, 0, 0);             // search -> measure
    run_frame(2, VACT, -1, 0, -1, -1, 0, 0);             // good=1
    run_frame(2, VACT - 1, -1, 0, -1, -1, 0, 0);         // wrong line count
    run_frame(0, VACT, -1, 0, -1, -1, 0, 0);
    run_frame(2, VACT, -1, 0, -1, -1, 0, 0);             // relock
    run_frame(2, VACT, -1, 0, -1, -1, 0, 0);
    run_frame(2, VACT, -1, 0, -1, 3, 0, 0);              // mid-frame reset
    run_frame(0, VACT, -1, 0, -1, -1, 0, 0);             // first report after reset
    run_frame(2, VACT, -1, 0, 2, -1, 0, 0);              // double hsync
    run_frame(2, VACT, 0, 2050, -1, -1, 0, 0);           // x saturation
    repeat (3) run_frame(2, VACT, -1, 0, -1, -1, 1, 0);  // vsync on line end
    repeat (2) run_frame(0, VACT, -1, 0, -1, -1, 0, 0);  // identical frames

    repeat (5) tick();
    chk("pixels_left", 64'(pixq.size()), 64'd0);
    chk("done_count",  64'(n_done),      64'(exp_dones));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 The module SHALL have parameter HACT, default 800, the required number of active pixels per line.
REQ-002 The module SHALL have parameter VACT, default 600, the required number of active lines per frame.
REQ-003 The module SHALL have parameter LOCKN, default 2, the number of consecutive good frames needed to assert locked.
REQ-004 Port clk SHALL be an input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-005 Port RSTn SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-006 Ports hsync, vsync, hvalid and vvalid SHALL be inputs, 1 bit each, active-high timing signals synchronous to clk.
REQ-007 Port pix SHALL be an input, 1 bit, the monochrome pixel (r=g=b).
REQ-008 Ports hcnt_o and vcnt_o SHALL be outputs, 11 bits each, the recovered active-area x and y coordinates.
REQ-009 Port pix_valid SHALL be an output, 1 bit, high when pix_o carries an active-area pixel.
REQ-010 Port pix_o SHALL be an output, 1 bit, the registered pixel.
REQ-011 Port locked SHALL be an output, 1 bit, the timing-lock status.
REQ-012 Port frame_done SHALL be an output, 1 bit, a one-cycle pulse at the end of each frame.
REQ-013 Port frame_ok SHALL be an output, 1 bit, the result of the last completed frame check.
REQ-014 Port ones_cnt SHALL be an output, 20 bits, the count of pix=1 active pixels in the last completed frame.

Function
REQ-015 An input cycle SHALL be active when hvalid&vvalid=1.
REQ-016 On an active cycle, the block SHALL output pix_valid=1, pix_o=pix, hcnt_o=x and vcnt_o=y on the next clk edge (latency 1).
REQ-017 The x counter SHALL increment on each active cycle and clear to 0 on the falling edge of hvalid.
REQ-018 The y counter SHALL increment on each hvalid falling edge that occurs while vvalid=1.
REQ-019 The block SHALL flag a line error when x at the hvalid falling edge is not equal to HACT.
REQ-020 The line error SHALL be sticky until the frame boundary.
REQ-021 x SHALL saturate at 2047 without wrapping.
REQ-022 The frame boundary SHALL be the rising edge of vsync.
REQ-023 At the frame boundary, the block SHALL compute frame_ok = (y==VACT) & no line error in the frame.
REQ-024 At the frame boundary, the block SHALL pulse frame_done for 1 cycle, latch ones_cnt, and clear x, y, the line-error flag and the running ones count.
REQ-025 The running ones count SHALL saturate at 2^20-1.
REQ-026 The FSM SHALL have three states: SEARCH, MEASURE and LOCKED.
REQ-027 In SEARCH, the first vsync rising edge SHALL move the FSM to MEASURE with the good-frame counter at 0; that edge's frame result is discarded.
REQ-028 In MEASURE, a good frame SHALL increment the good-frame counter.
REQ-029 In MEASURE, when the good-frame counter reaches LOCKN, the FSM SHALL move to LOCKED and assert locked.
REQ-030 In MEASURE, a bad frame SHALL reset the good-frame counter to 0 and keep the FSM in MEASURE.
REQ-031 In LOCKED, a bad frame SHALL move the FSM to SEARCH and deassert locked on the same edge that pulses frame_done.
REQ-032 hsync SHALL be used only for the same-line check: two hsync rising edges with no hvalid falling edge between them SHALL count as a line error.
REQ-033 If a vsync rising edge coincides with an hvalid falling edge, the line SHALL be checked and counted into the closing frame first, and the frame boundary processed after.
REQ-034 pix_valid SHALL be 0 on every cycle that is not active.

Reset
REQ-035 While RSTn=0, the block SHALL force all outputs to 0 (including locked, frame_ok, ones_cnt, hcnt_o and vcnt_o).
REQ-036 While RSTn=0, the FSM SHALL be in SEARCH and all counters SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for the next vsync rising edge.

Configuration
REQ-038 When macro VGA_RX_CRC_EN is defined, the block SHALL add output crc, 16 bits.
REQ-039 With VGA_RX_CRC_EN defined, the block SHALL compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, 1 bit per active pixel, MSB-first) over the frame's pixels.
REQ-040 With VGA_RX_CRC_EN defined, crc SHALL be latched at frame_done and the running CRC reinitialised; reset value of crc is 0.
REQ-041 When VGA_RX_CRC_EN is undefined, the crc port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-042 The bench SHALL cover nominal lock: 3 well-formed 800x600 frames with pix=0 -> frame_done x3, frame_ok=1, locked rises at the 3rd frame_done, ones_cnt=0.
REQ-043 The bench SHALL cover the all-ones frame after lock: pix=1 -> ones_cnt=480000, hcnt_o/vcnt_o reach 799/599 one cycle after the last active pixel.
REQ-044 The bench SHALL cover a short line: line 10 with 799 active pixels in a locked frame -> frame_ok=0, locked=0 at frame_done, FSM in SEARCH.
REQ-045 The bench SHALL cover wrong line count: 599 active lines -> frame_ok=0; in MEASURE the good count resets and lock needs 2 further good frames.
REQ-046 The bench SHALL cover mid-frame reset: RSTn low at line 300 -> all outputs 0 immediately; no frame_done until the 2nd vsync rising edge after release.
REQ-047 The bench SHALL cover CRC (VGA_RX_CRC_EN defined): an all-zero 800x600 frame -> crc equals the software model value; identical frames give identical crc.
